// File: rtl/baud_gen_frac.sv
// baud_gen_frac
// Fractional baud-rate generator producing single-cycle tick enables in the
// system clock domain instead of derived UART clocks.
//
// The rx_tick period is an integer divisor with an optional fractional part.
// The fraction accumulates every rx period, and each accumulator overflow
// stretches one period by a clock. tx_tick fires on every OVS-th rx_tick.
// A new divisor is held as pending and only takes effect at a period
// boundary, so a running UART never sees a truncated or stretched bit.
//
// Configuration macro: BAUD_FRAC_EN
//   defined   - fraction accumulator present (div_frac / DEF_FRAC honoured)
//   undefined - integer-only divider; div_frac and DEF_FRAC are ignored
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   generator enable; low holds counters in the start state
//   div_int   in   requested integer divisor (rx_tick period in clocks)
//   div_frac  in   requested fractional divisor (div_frac / 2^FRAC_W)
//   div_load  in   one-cycle strobe capturing div_int / div_frac
//   rx_tick   out  one-cycle pulse at OVS x baud
//   tx_tick   out  one-cycle pulse at baud, coincident with an rx_tick
//   cfg_err   out  sticky: last loaded div_int was < 2 and was clamped to 2

module baud_gen_frac #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 27,
    parameter int DEF_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              cfg_err
);

    localparam int OVS_W = $clog2(OVS);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_int_q, act_int_d;
    logic [DIV_W-1:0] pend_int_q, pend_int_d;
    logic             pend_vld_q, pend_vld_d;
    logic [OVS_W-1:0] ovs_q, ovs_d;
    logic             rx_q, rx_d;
    logic             tx_q, tx_d;
    logic             cfg_err_q, cfg_err_d;
    logic             carry;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        act_int_d  = act_int_q;
        pend_int_d = pend_int_q;
        pend_vld_d = pend_vld_q;
        ovs_d      = ovs_q;
        cfg_err_d  = cfg_err_q;
        rx_d       = 1'b0;
        tx_d       = 1'b0;
        carry      = 1'b0;
`ifdef BAUD_FRAC_EN
        acc_d       = acc_q;
        act_frac_d  = act_frac_q;
        pend_frac_d = pend_frac_q;
`endif

        if (!en) begin
            // Idle: adopt any pending divisor at once and park in the start state.
            if (pend_vld_q) begin
                act_int_d  = pend_int_q;
`ifdef BAUD_FRAC_EN
                act_frac_d = pend_frac_q;
`endif
                pend_vld_d = 1'b0;
            end
            cnt_d = act_int_d - DIV_W'(1);
            ovs_d = '0;
`ifdef BAUD_FRAC_EN
            acc_d = '0;
`endif
        end else if (cnt_q == '0) begin
            // Period boundary. The carry comes from the divisor that governed
            // the period just ending; a pending divisor sets the next length.
`ifdef BAUD_FRAC_EN
            carry = acc_sum[FRAC_W];
            acc_d = acc_sum[FRAC_W-1:0];
`endif
            if (pend_vld_q) begin
                act_int_d  = pend_int_q;
`ifdef BAUD_FRAC_EN
                act_frac_d = pend_frac_q;
`endif
                pend_vld_d = 1'b0;
            end
            cnt_d = act_int_d - DIV_W'(1) + DIV_W'(carry);
            rx_d  = 1'b1;
            if (ovs_q == OVS_W'(OVS - 1)) begin
                ovs_d = '0;
                tx_d  = 1'b1;
            end else begin
                ovs_d = ovs_q + OVS_W'(1);
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        // Capture comes last so a strobe on an application edge stays pending
        // for the following boundary instead of being consumed now.
        if (div_load) begin
            pend_vld_d = 1'b1;
            if (div_int < DIV_W'(2)) begin
                pend_int_d = DIV_W'(2);
                cfg_err_d  = 1'b1;
            end else begin
                pend_int_d = div_int;
                cfg_err_d  = 1'b0;
            end
`ifdef BAUD_FRAC_EN
            pend_frac_d = div_frac;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= DIV_W'(DEF_INT - 1);
            act_int_q  <= DIV_W'(DEF_INT);
            pend_int_q <= DIV_W'(DEF_INT);
            pend_vld_q <= 1'b0;
            ovs_q      <= '0;
            rx_q       <= 1'b0;
            tx_q       <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_int_q  <= act_int_d;
            pend_int_q <= pend_int_d;
            pend_vld_q <= pend_vld_d;
            ovs_q      <= ovs_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef BAUD_FRAC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            act_frac_q  <= FRAC_W'(DEF_FRAC);
            pend_frac_q <= FRAC_W'(DEF_FRAC);
        end else begin
            acc_q       <= acc_d;
            act_frac_q  <= act_frac_d;
            pend_frac_q <= pend_frac_d;
        end
    end
`endif

    assign rx_tick = rx_q;
    assign tx_tick = tx_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac
// Scoreboard bench for baud_gen_frac with OVS=4. Each scenario pushes the
// cycle stamps of the ticks it expects; a negedge monitor pops and compares
// them as rx_tick/tx_tick appear, flagging spurious and missed ticks.

module tb_baud_gen_frac;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        rx_tick;
    logic        tx_tick;
    logic        cfg_err;

    typedef struct {
        int unsigned cyc;
        logic        tx;
    } exp_t;

    exp_t        expQ[$];
    int unsigned cyc;
    int unsigned base;
    int          checkCount;
    int          passCount;
    bit          monOn;

    baud_gen_frac #(
        .DIV_W   (16),
        .FRAC_W  (4),
        .OVS     (4),
        .DEF_INT (27),
        .DEF_FRAC(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_int (div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .rx_tick (rx_tick),
        .tx_tick (tx_tick),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: after rising edge k, the following negedge sees cyc == k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
        checkCount++;
        if (obs == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic pushTick(input int unsigned at, input logic tx);
        exp_t e;
        e.cyc = at;
        e.tx  = tx;
        expQ.push_back(e);
    endtask

    // Monitor: every observed tick must match the head of the queue.
    always @(negedge clk) begin
        if (monOn) begin
            if (rx_tick || tx_tick) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_tick", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("rx_tick_time", cyc, e.cyc);
                    checkOutput("rx_tick_level", rx_tick, 1);
                    checkOutput("tx_tick_flag", tx_tick, e.tx);
                end
            end else if (expQ.size() > 0 && cyc > expQ[0].cyc) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("missed_tick", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic runUntil(input int unsigned t);
        while (cyc < t) step();
    endtask

    task automatic applyStimulus(input logic e, input logic ld, input logic [15:0] di, input logic [3:0] df);
        en       = e;
        div_load = ld;
        div_int  = di;
        div_frac = df;
        step();
        div_load = 1'b0;
    endtask

    // With en low: capture edge, then the application edge.
    task automatic loadIdle(input logic [15:0] di, input logic [3:0] df);
        applyStimulus(1'b0, 1'b1, di, df);
        step();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (expQ.size() > 0 && n < limit) begin
            step();
            n++;
        end
        if (expQ.size() > 0) begin
            checkOutput("drain_timeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    task automatic startRun();
        en   = 1'b1;
        base = cyc;
    endtask

    initial begin
        int unsigned t;
        int          acc;
        int          period;
        int          carry;

        checkCount = 0;
        passCount  = 0;
        monOn      = 1'b0;
        rst_n      = 1'b0;
        en         = 1'b0;
        div_load   = 1'b0;
        div_int    = '0;
        div_frac   = '0;

        // Reset state
        step();
        step();
        checkOutput("reset_rx_tick", rx_tick, 0);
        checkOutput("reset_tx_tick", tx_tick, 0);
        checkOutput("reset_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        monOn = 1'b1;
        step();

        // Default divisor: first tick after the 27th edge sampling en=1
        startRun();
        pushTick(base + 27, 1'b0);
        drain(40);
        en = 1'b0;
        step();

        // Integer divisor 4: rx every 4 clocks, tx on every 4th rx
        loadIdle(16'd4, 4'd0);
        startRun();
        for (int k = 0; k < 8; k++) pushTick(base + 4 * (k + 1), (k % 4) == 3);
        drain(50);
        en = 1'b0;
        step();

        // Divisor 4 + 8/16: periods 4,4,5,4,5,... when the fraction is built in
        loadIdle(16'd4, 4'd8);
        startRun();
        t      = base;
        acc    = 0;
        period = 4;
        for (int k = 0; k < 16; k++) begin
            t = t + period;
            pushTick(t, (k % 4) == 3);
`ifdef BAUD_FRAC_EN
            carry = (acc + 8) / 16;
            acc   = (acc + 8) % 16;
`else
            carry = 0;
`endif
            period = 4 + carry;
        end
        drain(100);
        checkOutput("frac_span_end", cyc - base, t - base);
        en = 1'b0;
        step();

        // Mid-period load: current 10-clock period completes, then 6
        loadIdle(16'd10, 4'd0);
        startRun();
        pushTick(base + 10, 1'b0);
        pushTick(base + 20, 1'b0);
        pushTick(base + 30, 1'b0);
        pushTick(base + 36, 1'b1);
        pushTick(base + 42, 1'b0);
        runUntil(base + 23);
        applyStimulus(1'b1, 1'b1, 16'd6, 4'd0);
        drain(40);
        en = 1'b0;
        step();

        // Load on the reload edge: takes effect one period later
        loadIdle(16'd10, 4'd0);
        startRun();
        pushTick(base + 10, 1'b0);
        pushTick(base + 20, 1'b0);
        pushTick(base + 26, 1'b0);
        pushTick(base + 32, 1'b1);
        runUntil(base + 9);
        applyStimulus(1'b1, 1'b1, 16'd6, 4'd0);
        drain(40);
        en = 1'b0;
        step();

        // div_int=1 clamps to 2 and flags cfg_err
        loadIdle(16'd1, 4'd0);
        checkOutput("cfg_err_set", cfg_err, 1);
        startRun();
        for (int k = 0; k < 4; k++) pushTick(base + 2 * (k + 1), (k % 4) == 3);
        drain(20);
        en = 1'b0;
        step();
        loadIdle(16'd5, 4'd0);
        checkOutput("cfg_err_clear", cfg_err, 0);
        startRun();
        pushTick(base + 5, 1'b0);
        pushTick(base + 10, 1'b0);
        drain(20);
        en = 1'b0;
        step();

        // en dropped on a reload edge, then for one cycle mid-period
        loadIdle(16'd8, 4'd0);
        startRun();
        pushTick(base + 16, 1'b0);
        pushTick(base + 28, 1'b0);
        pushTick(base + 36, 1'b0);
        runUntil(base + 7);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
        en = 1'b1;
        runUntil(base + 19);
        applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
        en = 1'b1;
        drain(40);
        en = 1'b0;
        step();

        // Asynchronous reset while a tick is high; defaults restored afterwards
        loadIdle(16'd1, 4'd0);
        startRun();
        for (int k = 0; k < 4; k++) pushTick(base + 2 * (k + 1), (k % 4) == 3);
        runUntil(base + 8);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rx", rx_tick, 0);
        checkOutput("async_rst_tx", tx_tick, 0);
        checkOutput("async_rst_cfg_err", cfg_err, 0);
        runUntil(base + 10);
        rst_n = 1'b1;
        pushTick(base + 37, 1'b0);
        drain(40);
        en = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
